half_sigmoid_backprop: RTL and testbench
========================================

// Module: half_sigmoid_backprop
// PURPOSE
//  Backward-pass partner of half_sigmoid: computes dL/dx = g * y * (1 - y) in IEEE-754 binary16.
//  y is the forward sigmoid output; g is the upstream gradient.
//  Fully pipelined, one result per clock, fixed latency, no backpressure.
//  Sits in the training datapath after the error/gradient stage and before the weight-update MAC.
// PARAMETERS
//  FRAC_BITS   16       fraction width of internal fixed-point y and (1-y); y quantised to Q1.FRAC_BITS
//  QNAN        16'h7E00 canonical quiet-NaN pattern driven on c for invalid results
// PORTS
//  clk        in   1   rising-edge clock
//  rstn       in   1   synchronous active-low reset, sampled on posedge clk
//  in_valid   in   1   y and g valid this cycle
//  y          in   16  half: forward sigmoid output
//  g          in   16  half: upstream gradient
//  out_valid  out  1   c valid this cycle
//  c          out  16  half: g*y*(1-y)
// BEHAVIOUR
//  Reset:
//   - One clock; reset is synchronous and active-low (rstn).
//   - rstn=0 at a posedge clears all valid stages, out_valid and c to 0.
//   - In-flight data is discarded: out_valid is 0 from the edge after rstn is sampled low
//     until 3 edges after the first in_valid sampled with rstn=1.
//  Timing:
//   - Latency exactly 3 cycles: in_valid=1 sampled at edge k gives out_valid=1 and c after edge k+3.
//   - Throughput 1/cycle; back-to-back inputs allowed.
//   - Data regs may load when in_valid=0, but out_valid tracks in_valid through a 3-bit shift register.
//  S1 (register + decode y):
//   - u = y as unsigned Q1.FRAC_BITS, truncated.
//   - y negative (incl -0), zero, or <2^-FRAC_BITS -> u=0.
//   - y >= 1.0 or +inf -> u = 1<<FRAC_BITS.
//   - Subnormal y -> u=0.
//   - y NaN sets nan flag. Decode g into sign / exp / 11-bit mantissa (hidden bit; subnormal g flushed to 0).
//  S2: d = (u * ((1<<FRAC_BITS) - u)) >> FRAC_BITS, truncated; 0 <= d <= 1<<(FRAC_BITS-2).
//  S3 (multiply + normalise):
//   - p = g_mant(11b) * d(FRAC_BITS+1b).
//   - Leading-one normalise; exponent = g_exp - FRAC_BITS + shift.
//   - Round to nearest-even on 10-bit mantissa; rounding carry increments exponent.
//   - Result exp <= 0 flushes to signed zero (no subnormal outputs).
//   - Overflow is impossible for finite g since |d| <= 0.25.
//  Sign: sign(c) = sign(g), including zero results.
//  Specials (priority order):
//   1. y NaN or g NaN -> QNAN.
//   2. g +/-inf and d == 0 -> QNAN.
//   3. g +/-inf and d > 0 -> +/-inf (0x7C00 / 0xFC00).
//   4. g zero or d == 0 -> signed zero.
//  Edge cases:
//   - Reset asserted in the same cycle as in_valid=1: reset wins; that sample is dropped.
// STRUCTURE
//  Package half_pkg:
//   - typedef half_t struct packed {logic sign; logic [4:0] exp; logic [9:0] mant;}
//   - HALF_EXP_BIAS=15, HALF_POS_INF=16'h7C00, HALF_QNAN=16'h7E00, HALF_ONE=16'h3C00
//   - function is_nan(half_t)
//  Sub-module half_fixed_mult implements S3:
//   - Inputs: half g operand (decoded), unsigned fixed d, exponent offset.
//   - Output: normalised, rounded half with special-case handling; one register stage.
//   - Reusable by other derivative blocks (e.g. tanh backprop).
//  Top level holds S1/S2 datapath, nan/inf flag pipeline, and the valid shift register.
// TESTING
//  Cycle-accurate scoreboard: real-valued model rounded to half, flags any out_valid mismatch vs
//  a 3-cycle-delayed in_valid.
//  1. y=0x3800 (0.5), g=0x3C00 (1.0) -> c=0x3400 (0.25), out_valid exactly 3 cycles later.
//  2. y=0x3400 (0.25), g=0xC000 (-2.0) -> c=0xB600 (-0.375).
//  3. y=0x3C00 (1.0), g=0x3C00 -> c=0x0000; y=0xB800 (-0.5), g=0xBC00 -> c=0x8000.
//  4. Specials:
//     - y=0x7E00, g=0x3C00 -> 0x7E00
//     - y=0x3800, g=0x7C00 -> 0x7C00
//     - y=0x3C00, g=0xFC00 -> 0x7E00
//  5. 11 back-to-back samples (y = half_sigmoid of -5.5,-0.5,0.5,-0.25,0.25,1,2,3,1.234567,4.5678,-3.21;
//     g=0x3C00) -> 11 consecutive out_valid, each within 1 ulp of y(1-y).
//  6. Drive stream, pull rstn low for 1 cycle mid-stream -> out_valid=0 and c=0 on the next cycle;
//     only post-reset samples emerge, at 3-cycle latency.

Source files
------------

// File: rtl/half_pkg.sv
// Shared binary16 types, constants and helpers for the half-precision datapath blocks.
package half_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] mant;
    } half_t;

    localparam int          HALF_EXP_BIAS = 15;
    localparam int          HALF_MANT_W   = 10;
    localparam logic [15:0] HALF_POS_INF  = 16'h7C00;
    localparam logic [15:0] HALF_QNAN     = 16'h7E00;
    localparam logic [15:0] HALF_ONE      = 16'h3C00;

    function automatic logic is_nan(input half_t h);
        return (h.exp == 5'h1F) && (h.mant != 10'h0);
    endfunction

endpackage

// File: rtl/half_sigmoid_backprop_if.sv
// Streaming operand/result bundle for half_sigmoid_backprop (no backpressure).
interface half_sigmoid_backprop_if;
    logic        in_valid;
    logic [15:0] y;
    logic [15:0] g;
    logic        out_valid;
    logic [15:0] c;

    modport master (output in_valid, y, g, input out_valid, c);
    modport slave  (input in_valid, y, g, output out_valid, c);
endinterface

// File: rtl/half_fixed_mult.sv
// Half (decoded) times unsigned fixed-point multiply with leading-one normalise,
// round-to-nearest-even, flush-to-zero and special-case selection. One register stage.
module half_fixed_mult import half_pkg::*; #(
    parameter int unsigned FRAC_BITS = 16,
    parameter logic [15:0] QNAN      = 16'h7E00
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    input  logic               nan,
    input  logic               g_inf,
    input  logic               g_sign,
    input  logic [4:0]         g_exp,
    input  logic [10:0]        g_mant,
    input  logic [FRAC_BITS:0] d,
    input  logic [7:0]         exp_off,
    output logic               out_valid,
    output logic [15:0]        c
);
    localparam int unsigned PW = 12 + FRAC_BITS;

    logic [PW-1:0] p;
    logic [PW-1:0] pn;
    logic [9:0]    mant10;
    logic          guard;
    logic          sticky;
    logic [10:0]   m_rnd;
    int            lead;
    int            e_res;
    logic [15:0]   res;

    // Multiply, normalise to the leading one, round and pick the special-case result.
    always_comb begin
        p    = PW'(g_mant) * PW'(d);
        lead = 0;
        for (int i = 0; i < int'(PW); i++) begin
            if (p[i]) lead = i;
        end
        pn     = p << (int'(PW) - 1 - lead);
        mant10 = 10'(pn >> (PW - 11));
        guard  = pn[PW-12];
        sticky = |pn[PW-13:0];
        m_rnd  = {1'b0, mant10} + 11'(guard & (sticky | mant10[0]));
        // Exponent is biased: g_exp already carries the bias, exp_off removes fixed-point scaling.
        e_res  = int'(g_exp) + lead - int'(exp_off) + int'(m_rnd[10]);
        res    = {g_sign, 15'h0};
        if (nan) begin
            res = QNAN;
        end else if (g_inf) begin
            res = (d == '0) ? QNAN : {g_sign, 5'h1F, 10'h0};
        end else if (p != '0 && e_res > 0) begin
            res = {g_sign, e_res[4:0], m_rnd[9:0]};
        end
    end

    // Output register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            c         <= 16'h0;
        end else begin
            out_valid <= in_valid;
            c         <= res;
        end
    end

endmodule

// File: rtl/half_sigmoid_backprop.sv
// Sigmoid backward pass: c = g * y * (1 - y) in binary16, three-cycle latency, one result/clock.
module half_sigmoid_backprop import half_pkg::*; #(
    parameter int unsigned FRAC_BITS = 16,
    parameter logic [15:0] QNAN      = 16'h7E00
) (
    input logic                     clk,
    input logic                     rstn,
    half_sigmoid_backprop_if.slave  bus
);
    localparam int unsigned         WW      = FRAC_BITS + 26;
    localparam logic [FRAC_BITS:0]  ONE_FIX = (FRAC_BITS+1)'(1) << FRAC_BITS;

    logic [2:0]           vld_sr;
    half_t                y_q, g_q;

    logic [WW-1:0]        wide;
    logic [FRAC_BITS:0]   u_c;
    logic                 nan_c, inf_c;
    logic [10:0]          gm_c;

    logic [FRAC_BITS:0]   u_q;
    logic                 nan1_q, inf1_q, gs1_q;
    logic [4:0]           ge1_q;
    logic [10:0]          gm1_q;

    logic [2*FRAC_BITS+1:0] prod;
    logic [FRAC_BITS:0]   d_q;
    logic                 nan2_q, inf2_q, gs2_q;
    logic [4:0]           ge2_q;
    logic [10:0]          gm2_q;

    // Decode captured y into truncated Q1.FRAC_BITS and g into hidden-bit mantissa plus flags.
    always_comb begin
        wide = '0;
        u_c  = '0;
        if (y_q.sign || y_q.exp == 5'h0) begin
            u_c = '0;
        end else if (int'(y_q.exp) >= HALF_EXP_BIAS) begin
            u_c = ONE_FIX;
        end else begin
            wide = WW'({1'b1, y_q.mant}) << (int'(y_q.exp) + int'(FRAC_BITS));
            u_c  = (FRAC_BITS+1)'(wide >> (HALF_EXP_BIAS + HALF_MANT_W));
        end
        nan_c = is_nan(y_q) || is_nan(g_q);
        inf_c = (g_q.exp == 5'h1F) && (g_q.mant == 10'h0);
        // Subnormal g flushes to zero.
        gm_c  = (g_q.exp == 5'h0) ? 11'h0 : {1'b1, g_q.mant};
        prod  = (2*FRAC_BITS+2)'(u_q) * (2*FRAC_BITS+2)'(ONE_FIX - u_q);
    end

    // Input capture, decode stage and y(1-y) stage; valid travels alongside in a shift register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_sr <= 3'b0;
            y_q    <= '0;
            g_q    <= '0;
            u_q    <= '0;
            nan1_q <= 1'b0;
            inf1_q <= 1'b0;
            gs1_q  <= 1'b0;
            ge1_q  <= 5'h0;
            gm1_q  <= 11'h0;
            d_q    <= '0;
            nan2_q <= 1'b0;
            inf2_q <= 1'b0;
            gs2_q  <= 1'b0;
            ge2_q  <= 5'h0;
            gm2_q  <= 11'h0;
        end else begin
            vld_sr <= {vld_sr[1:0], bus.in_valid};
            y_q    <= bus.y;
            g_q    <= bus.g;
            u_q    <= u_c;
            nan1_q <= nan_c;
            inf1_q <= inf_c;
            gs1_q  <= g_q.sign;
            ge1_q  <= g_q.exp;
            gm1_q  <= gm_c;
            d_q    <= (FRAC_BITS+1)'(prod >> FRAC_BITS);
            nan2_q <= nan1_q;
            inf2_q <= inf1_q;
            gs2_q  <= gs1_q;
            ge2_q  <= ge1_q;
            gm2_q  <= gm1_q;
        end
    end

    half_fixed_mult #(
        .FRAC_BITS (FRAC_BITS),
        .QNAN      (QNAN)
    ) u_mult (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (vld_sr[2]),
        .nan       (nan2_q),
        .g_inf     (inf2_q),
        .g_sign    (gs2_q),
        .g_exp     (ge2_q),
        .g_mant    (gm2_q),
        .d         (d_q),
        .exp_off   (8'(HALF_MANT_W + int'(FRAC_BITS))),
        .out_valid (bus.out_valid),
        .c         (bus.c)
    );

endmodule

// File: tb/tb_half_sigmoid_backprop.sv
// Self-checking bench for half_sigmoid_backprop: directed cases plus randomized stream
// against a real-valued reference model with a 3-cycle latency scoreboard.
module tb_half_sigmoid_backprop;
    import half_pkg::*;

    typedef struct {
        bit          v;
        bit          ck;
        logic [15:0] c;
    } ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    ent_t hist[$];

    half_sigmoid_backprop_if bus();

    half_sigmoid_backprop #(
        .FRAC_BITS (16),
        .QNAN      (16'h7E00)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Normal binary16 value only.
    function automatic real half_to_real(input logic [15:0] h);
        real m;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        return m * pow2(int'(h[14:10]) - 15);
    endfunction

    // Positive magnitude to half, nearest-even, results below the normal range flush to zero.
    function automatic logic [15:0] real_to_half(input real a_in, input logic s);
        real a = a_in;
        real sc, fr;
        int  e = 0;
        int  m, be, mm;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        sc = a * 1024.0;
        m  = int'($floor(sc));
        fr = sc - $floor(sc);
        if (fr > 0.5 || (fr == 0.5 && (m % 2) == 1)) m++;
        if (m == 2048) begin m = 1024; e++; end
        be = e + 15;
        if (be <= 0) return {s, 15'h0};
        if (be >= 31) return {s, 5'h1F, 10'h0};
        mm = m - 1024;
        return {s, be[4:0], mm[9:0]};
    endfunction

    function automatic logic [15:0] sigmoid_half(input real x);
        return real_to_half(1.0 / (1.0 + $exp(-x)), 1'b0);
    endfunction

    // Reference: y quantised to Q1.16 by truncation, d = floor(u(1-u)), then g*d rounded to half.
    function automatic logic [15:0] model(input logic [15:0] y, input logic [15:0] g);
        half_t  yh, gh;
        longint u, d;
        real    r;
        yh = y;
        gh = g;
        if (is_nan(yh) || is_nan(gh)) return HALF_QNAN;
        if (yh.sign || yh.exp == 5'h0) u = 0;
        else if (yh.exp == 5'h1F) u = 65536;
        else u = longint'($floor(half_to_real(y) * 65536.0));
        if (u > 65536) u = 65536;
        d = (u * (65536 - u)) / 65536;
        if (gh.exp == 5'h1F) begin
            if (d == 0) return HALF_QNAN;
            return gh.sign ? 16'hFC00 : HALF_POS_INF;
        end
        if (gh.exp == 5'h0 || d == 0) return {gh.sign, 15'h0};
        r = half_to_real({1'b0, g[14:0]}) * real'(d) / 65536.0;
        return real_to_half(r, gh.sign);
    endfunction

    // One clock: drive at negedge, advance the scoreboard at posedge, compare 1 time unit later.
    task automatic step(input logic r, input logic v, input logic [15:0] yy, input logic [15:0] gg,
                        input bit use_exp, input logic [15:0] exp_c);
        ent_t e, cur;
        @(negedge clk);
        rstn         = r;
        bus.in_valid = v;
        bus.y        = yy;
        bus.g        = gg;
        @(posedge clk);
        if (!r) begin
            hist.delete();
            e.v = 1'b0; e.ck = 1'b0; e.c = 16'h0;
            repeat (3) hist.push_back(e);
            cur.v = 1'b0; cur.ck = 1'b1; cur.c = 16'h0;
        end else begin
            e.v  = v;
            e.ck = v;
            e.c  = use_exp ? exp_c : model(yy, gg);
            hist.push_back(e);
            cur = hist.pop_front();
        end
        #1;
        check("out_valid", 16'(bus.out_valid), 16'(cur.v));
        if (cur.ck && cur.v) check("c", bus.c, cur.c);
        if (cur.ck && !cur.v) check("c_after_reset", bus.c, cur.c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    real         xs[11] = '{-5.5, -0.5, 0.5, -0.25, 0.25, 1.0, 2.0, 3.0, 1.234567, 4.5678, -3.21};
    logic [15:0] sp[8]  = '{16'h0000, 16'h8000, 16'h3C00, 16'h7C00,
                            16'h7E00, 16'hFC00, 16'h0001, 16'h3800};

    initial begin
        logic [15:0] ry, rg;
        logic        rr, rv;
        bus.in_valid = 1'b0;
        bus.y        = 16'h0;
        bus.g        = 16'h0;

        // Reset: outputs cleared.
        repeat (2) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

        // Directed values with spec-given results.
        step(1'b1, 1'b1, 16'h3800, 16'h3C00, 1'b1, 16'h3400);
        idle(4);
        step(1'b1, 1'b1, 16'h3400, 16'hC000, 1'b1, 16'hB600);
        step(1'b1, 1'b1, 16'h3C00, 16'h3C00, 1'b1, 16'h0000);
        step(1'b1, 1'b1, 16'hB800, 16'hBC00, 1'b1, 16'h8000);
        step(1'b1, 1'b1, 16'h7E00, 16'h3C00, 1'b1, 16'h7E00);
        step(1'b1, 1'b1, 16'h3800, 16'h7C00, 1'b1, 16'h7C00);
        step(1'b1, 1'b1, 16'h3C00, 16'hFC00, 1'b1, 16'h7E00);
        idle(4);

        // Back-to-back sigmoid outputs.
        for (int i = 0; i < 11; i++)
            step(1'b1, 1'b1, sigmoid_half(xs[i]), 16'h3C00, 1'b0, 16'h0);
        idle(4);

        // Reset mid-stream; the sample presented with reset low is dropped.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, sigmoid_half(xs[i]), 16'h4000, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h3800, 16'h3C00, 1'b0, 16'h0);
        for (int i = 5; i < 11; i++) step(1'b1, 1'b1, sigmoid_half(xs[i]), 16'hC200, 1'b0, 16'h0);
        idle(4);

        // Randomized stream with occasional resets and idle cycles.
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 59) != 0);
            rv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       ry = 16'($urandom);
                3:       ry = sp[$urandom_range(0, 7)];
                default: ry = {1'b0, 5'($urandom_range(0, 15)), 10'($urandom)};
            endcase
            case ($urandom_range(0, 3))
                0:       rg = 16'($urandom);
                3:       rg = sp[$urandom_range(0, 7)];
                default: rg = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            endcase
            step(rr, rv, ry, rg, 1'b0, 16'h0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
